// File: rtl/computer.sv
// Eight-bit bus-oriented teaching computer: 16x8 RAM, A/B/OUT registers, an
// ADD/SUB ALU with carry/zero flags, and a fixed six-microstep control sequencer.
`timescale 1ns/1ps

module register_8 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] latched_data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) latched_data <= '0;
    else if (load) latched_data <= bus;
  end

endmodule

module computer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic [DATA_W-1:0] out_val
);

  localparam int ADDR_W = 4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_STA = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JC  = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5} step_t;
  typedef enum logic [2:0] {BUS_NONE, BUS_PC, BUS_RAM, BUS_OPND, BUS_A, BUS_ALU} bus_sel_t;

  // Power-up image only; reset never touches the RAM.
  logic [DATA_W-1:0] ram [16] = '{
    8'h1E, 8'h2F, 8'h30, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h44, 8'h22
  };

  step_t             step;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] out_reg;
  logic              c_flag;
  logic              z_flag;
  logic              halted;

  logic [DATA_W-1:0] a_val;
  logic [DATA_W-1:0] b_val;
  logic [DATA_W-1:0] bus;
  logic [DATA_W:0]   alu_res;
  logic [3:0]        opcode;

  bus_sel_t bus_sel;
  logic     mar_ld, ir_ld, pc_inc, pc_ld, a_ld, b_ld, ram_we, out_ld, flags_ld, halt_set;

  // Carry out for ADD; for SUB the carry of A + ~B + 1 is the no-borrow flag (A >= B).
  function automatic logic [DATA_W:0] alu(input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b,
                                          input logic              sub);
    logic [DATA_W:0] r;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
    else     r = {1'b0, a} + {1'b0, b};
    return r;
  endfunction

  function automatic step_t next_step(input step_t s);
    step_t n;
    case (s)
      T0:      n = T1;
      T1:      n = T2;
      T2:      n = T3;
      T3:      n = T4;
      T4:      n = T5;
      default: n = T0;
    endcase
    return n;
  endfunction

  register_8 #(.DATA_W(DATA_W)) u_register_A (
    .clk          (clk),
    .reset        (reset),
    .load         (a_ld),
    .bus          (bus),
    .latched_data (a_val)
  );

  register_8 #(.DATA_W(DATA_W)) u_register_B (
    .clk          (clk),
    .reset        (reset),
    .load         (b_ld),
    .bus          (bus),
    .latched_data (b_val)
  );

  assign opcode  = ir[7:4];
  assign alu_res = alu(a_val, b_val, opcode == OP_SUB);

  always_comb begin
    bus_sel  = BUS_NONE;
    mar_ld   = 1'b0;
    ir_ld    = 1'b0;
    pc_inc   = 1'b0;
    pc_ld    = 1'b0;
    a_ld     = 1'b0;
    b_ld     = 1'b0;
    ram_we   = 1'b0;
    out_ld   = 1'b0;
    flags_ld = 1'b0;
    halt_set = 1'b0;
    if (!halted) begin
      case (step)
        T0: begin
          bus_sel = BUS_PC;
          mar_ld  = 1'b1;
        end
        T1: begin
          bus_sel = BUS_RAM;
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_LDB, OP_STA: begin
              bus_sel = BUS_OPND;
              mar_ld  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              bus_sel  = BUS_ALU;
              a_ld     = 1'b1;
              flags_ld = 1'b1;
            end
            OP_LDI: begin
              bus_sel = BUS_OPND;
              a_ld    = 1'b1;
            end
            OP_JMP: begin
              bus_sel = BUS_OPND;
              pc_ld   = 1'b1;
            end
            OP_JC: begin
              bus_sel = c_flag ? BUS_OPND : BUS_NONE;
              pc_ld   = c_flag;
            end
            OP_JZ: begin
              bus_sel = z_flag ? BUS_OPND : BUS_NONE;
              pc_ld   = z_flag;
            end
            OP_OUT: begin
              bus_sel = BUS_A;
              out_ld  = 1'b1;
            end
            OP_HLT:  halt_set = 1'b1;
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              bus_sel = BUS_RAM;
              a_ld    = 1'b1;
            end
            OP_LDB: begin
              bus_sel = BUS_RAM;
              b_ld    = 1'b1;
            end
            OP_STA: begin
              bus_sel = BUS_A;
              ram_we  = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (bus_sel)
      BUS_PC:   bus = {{(DATA_W-ADDR_W){1'b0}}, pc};
      BUS_RAM:  bus = ram[mar];
      BUS_OPND: bus = {{(DATA_W-ADDR_W){1'b0}}, ir[ADDR_W-1:0]};
      BUS_A:    bus = a_val;
      BUS_ALU:  bus = alu_res[DATA_W-1:0];
      default:  bus = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[mar] <= bus;
  end

  // The halting edge itself does not advance the microstep, so a halted machine rests at T2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step    <= T0;
      pc      <= '0;
      mar     <= '0;
      ir      <= '0;
      out_reg <= '0;
      c_flag  <= 1'b0;
      z_flag  <= 1'b0;
      halted  <= 1'b0;
    end else if (!halted) begin
      if (mar_ld) mar <= bus[ADDR_W-1:0];
      if (ir_ld) ir <= bus;
      if (pc_ld) pc <= bus[ADDR_W-1:0];
      else if (pc_inc) pc <= pc + 1'b1;
      if (out_ld) out_reg <= bus;
      if (flags_ld) begin
        c_flag <= alu_res[DATA_W];
        z_flag <= (alu_res[DATA_W-1:0] == '0);
      end
      if (halt_set) halted <= 1'b1;
      else step <= next_step(step);
    end
  end

  assign out_val = out_reg;

endmodule

// File: tb/tb_computer.sv
// Directed bench for the computer: default program timing, halt freeze, async reset,
// ALU flags and conditional jumps, store, and PC wrap-around.
`timescale 1ns/1ps

module tb_computer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] out_val;

  int errors = 0;
  int checks = 0;

  logic [7:0] prog [16];

  computer dut (
    .clk     (clk),
    .reset   (reset),
    .out_val (out_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) dut.ram[i] <= prog[i];
    #1;
  endtask

  // Default program: LDA 14; LDB 15; ADD; OUT; HLT with 0x44 + 0x22.
  task automatic run_default(input string pass);
    release_reset();
    edges(4);
    check({pass, " A@4"}, dut.u_register_A.latched_data, 32'h44);
    edges(6);
    check({pass, " B@10"}, dut.u_register_B.latched_data, 32'h22);
    edges(2);
    check({pass, " A@12"}, dut.u_register_A.latched_data, 32'h44);
    edges(10);
    check({pass, " out@22"}, out_val, 32'h66);
    edges(2);
    check({pass, " B@24"}, dut.u_register_B.latched_data, 32'h22);
    check({pass, " A@24"}, dut.u_register_A.latched_data, 32'h66);
    check({pass, " C@24"}, dut.c_flag, 32'h0);
    check({pass, " Z@24"}, dut.z_flag, 32'h0);
    edges(3);
    check({pass, " pc@27"}, dut.pc, 32'h5);
    check({pass, " halted@27"}, dut.halted, 32'h1);
    edges(100);
    check({pass, " frozen pc"}, dut.pc, 32'h5);
    check({pass, " frozen step"}, dut.step, 32'h2);
    check({pass, " frozen A"}, dut.u_register_A.latched_data, 32'h66);
    check({pass, " frozen out"}, out_val, 32'h66);
    check({pass, " frozen halted"}, dut.halted, 32'h1);
  endtask

  initial begin
    reset = 1'b1;
    edges(2);
    check("reset out_val", out_val, 32'h00);
    check("reset pc", dut.pc, 32'h0);
    check("reset step", dut.step, 32'h0);
    check("power-up ram0", dut.ram[0], 32'h1E);

    run_default("run1");

    // Asynchronous reset from the halted state, away from any clock edge.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async out_val", out_val, 32'h00);
    check("async A", dut.u_register_A.latched_data, 32'h00);
    check("async pc", dut.pc, 32'h0);
    check("async halted", dut.halted, 32'h0);
    check("ram kept 0", dut.ram[0], 32'h1E);
    check("ram kept 14", dut.ram[14], 32'h44);

    // Reset in the middle of ADD, just before its execute edge.
    release_reset();
    edges(14);
    check("pre-abort A", dut.u_register_A.latched_data, 32'h44);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort A", dut.u_register_A.latched_data, 32'h00);
    check("abort B", dut.u_register_B.latched_data, 32'h00);
    check("abort pc", dut.pc, 32'h0);
    check("abort step", dut.step, 32'h0);
    check("abort out_val", out_val, 32'h00);
    run_default("run2");

    // LDB 14; LDI 15; ADD; JZ 6; HLT; HLT; LDA 15; LDB 13; SUB; JC 0; OUT; STA 13; HLT
    reset = 1'b1;
    prog = '{8'h2E, 8'h6F, 8'h30, 8'h96, 8'hF0, 8'hF0, 8'h1F, 8'h2D,
             8'h40, 8'h80, 8'hE0, 8'h5D, 8'hF0, 8'h06, 8'hF1, 8'h05};
    load_prog();
    release_reset();
    edges(9);
    check("LDI A", dut.u_register_A.latched_data, 32'h0F);
    edges(6);
    check("ADD wrap A", dut.u_register_A.latched_data, 32'h00);
    check("ADD wrap C", dut.c_flag, 32'h1);
    check("ADD wrap Z", dut.z_flag, 32'h1);
    edges(6);
    check("JZ taken pc", dut.pc, 32'h6);
    edges(13);
    check("LDB 6", dut.u_register_B.latched_data, 32'h06);
    edges(5);
    check("SUB A", dut.u_register_A.latched_data, 32'hFF);
    check("SUB C", dut.c_flag, 32'h0);
    check("SUB Z", dut.z_flag, 32'h0);
    edges(6);
    check("JC not taken pc", dut.pc, 32'hA);
    edges(6);
    check("OUT FF", out_val, 32'hFF);
    edges(7);
    check("STA ram13", dut.ram[13], 32'hFF);
    edges(5);
    check("prog2 halted", dut.halted, 32'h1);
    check("prog2 pc", dut.pc, 32'hD);

    // Sixteen NOPs (address 0 holds an unused opcode, which also acts as NOP).
    reset = 1'b1;
    prog = '{8'hB5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load_prog();
    release_reset();
    edges(2);
    check("nop first ir", dut.ir, 32'hB5);
    check("nop first pc", dut.pc, 32'h1);
    edges(90);
    check("pc wrap to 0", dut.pc, 32'h0);
    check("nop ir last", dut.ir, 32'h00);
    edges(6);
    check("refetch pc", dut.pc, 32'h1);
    check("refetch ir", dut.ir, 32'hB5);
    check("nop A", dut.u_register_A.latched_data, 32'h00);
    check("nop halted", dut.halted, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/computer.md
COMPUTER -- requirements
Module: computer

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 out_val  output  8  output register contents, driven by OUT instruction.
REQ-004 Hierarchy SHALL contain instances u_register_A and u_register_B, each exposing an 8-bit register named latched_data holding the A and B register values.

Function
REQ-005 Architecture: 8-bit shared bus, 4-bit PC, 4-bit MAR, 8-bit IR, 16x8 RAM, registers A, B, OUT, 8-bit ALU, carry/zero flags, microsequenced control unit.
REQ-006 Instruction format: IR[7:4] opcode, IR[3:0] operand (address or immediate).
REQ-007 Opcodes: 0 NOP; 1 LDA A<=M[op]; 2 LDB B<=M[op]; 3 ADD A<=A+B; 4 SUB A<=A-B; 5 STA M[op]<=A; 6 LDI A<={4'b0,op}; 7 JMP PC<=op; 8 JC jump if C=1; 9 JZ jump if Z=1; E OUT out_val<=A; F HLT; A-D behave as NOP.
REQ-008 Every instruction SHALL take exactly six microsteps T0-T5, one clock each, then return to T0.
REQ-009 T0 MAR<=PC; T1 IR<=M[MAR], PC<=PC+1 (wraps 15->0); T2 execute step 1; T3 execute step 2; T4-T5 idle.
REQ-010 LDA/LDB/STA: T2 MAR<=op; T3 register or memory transfer.
REQ-011 ADD/SUB/LDI/JMP/JC/JZ/OUT: complete in T2; T3 idle.
REQ-012 ADD/SUB: 8-bit result modulo 256; C = carry out (ADD) or no-borrow, i.e. A>=B (SUB); Z = result==0; flags update only on ADD/SUB.
REQ-013 Conditional jump not taken: PC unchanged (already incremented).
REQ-014 HLT: at T2 set halted; while halted, microstep counter, PC and all registers freeze; only reset clears halt.
REQ-015 Bus has exactly one driver per microstep; undriven bus reads 8'h00.
REQ-016 RAM is synchronous-write; read data is available to the register loading in the same microstep.
REQ-017 RAM initial contents (power-up, not reset): 0:0x1E LDA 14; 1:0x2F LDB 15; 2:0x30 ADD; 3:0xE0 OUT; 4:0xF0 HLT; 5-13:0x00; 14:0x44; 15:0x22.
REQ-018 out_val SHALL be the registered OUT value, never combinational from the bus.

Reset
REQ-019 reset asserted SHALL immediately clear PC, MAR, IR, A, B, OUT, flags, halted; microstep to T0; out_val=0x00.
REQ-020 RAM contents SHALL NOT be altered by reset.
REQ-021 Reset asserted mid-instruction aborts it; execution restarts at address 0, T0, after deassertion.
REQ-022 First rising edge after deassertion executes T0 of instruction 0.

Verification
REQ-023 Release reset; after 4 edges A=0x44; after 12 edges A still 0x44.
REQ-024 After 10 edges B=0x22; after 24 edges B=0x22, A=0x66, C=0, Z=0.
REQ-025 After 22 edges out_val=0x66; PC=5 and halted=1 after 27 edges; state frozen through 100 further edges.
REQ-026 Assert reset at edge 15 (mid-ADD) -> out_val=0x00, A=0x00, PC=0 immediately; rerun reproduces REQ-023 to REQ-025 timing.
REQ-027 Program LDI 15; ADD with B=0xF1 -> A=0x00, C=1, Z=1; JZ taken; SUB 0x05-0x06 -> A=0xFF, C=0.
REQ-028 PC wrap: program of 16 NOPs -> PC goes 15->0 and fetches address 0 again.
